// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings shared by the store unit and the writeback load-extract path.
//   SZ_*   : st_size encodings (byte / half / word / illegal)
//   BM_*   : right-aligned byte masks for each access size
//   st_state_e : store-unit FSM states
package riscv_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;
    localparam logic [3:0] BM_B = 4'b0001;
    localparam logic [3:0] BM_H = 4'b0011;
    localparam logic [3:0] BM_W = 4'b1111;
    typedef enum logic [1:0] {ST_IDLE, ST_WR0, ST_WR1, ST_DONE} st_state_e;
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: combinational lane placement of a store across two words.
//   i_off   : byte offset within the word (addr[1:0])
//   i_size  : access size (SZ_B / SZ_H / SZ_W)
//   i_data  : right-aligned store data
//   o_m8    : byte enables for low word [3:0] and high word [7:4]
//   o_d64   : lane-positioned data for low word [31:0] and high word [63:32]
//   o_split : access spills into the next word
module store_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_data,
    output logic [7:0]  o_m8,
    output logic [63:0] o_d64,
    output logic        o_split
);
    logic [3:0]  w_m4;
    logic [31:0] w_keep;
    always_comb begin
        w_m4    = (i_size == SZ_B) ? BM_B : (i_size == SZ_H) ? BM_H : BM_W;
        // zero bytes beyond the access size so disabled lanes carry 0
        w_keep  = {{8{w_m4[3]}}, {8{w_m4[2]}}, {8{w_m4[1]}}, {8{w_m4[0]}}};
        o_m8    = {4'b0000, w_m4} << i_off;
        o_d64   = {32'b0, i_data & w_keep} << {i_off, 3'b000};
        o_split = |o_m8[7:4];
    end
endmodule

// File: rtl/dmem_store_unit.sv
// dmem_store_unit: turns one store request into one or two word-aligned, byte-enabled writes.
//   clk, rst                : clock, synchronous active-high reset
//   st_valid_i/st_ready_o   : request handshake (ready only in IDLE)
//   st_addr_i/size_i/data_i : byte address, size, right-aligned data
//   dmem_we_o/dmem_ready_i  : write valid (held until accepted) / memory accept
//   dmem_addr_o/wdata_o/be_o: word address, lane data, byte enables
//   stall_o                 : freeze upstream while busy
//   done_o / err_o          : one-cycle retire pulse / illegal-size pulse
module dmem_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [1:0]        st_size_i,
    input  logic [31:0]       st_data_i,
    output logic              dmem_we_o,
    input  logic              dmem_ready_i,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o
);
    st_state_e         r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_data;
    logic              r_err;
    logic [7:0]        w_m8;
    logic [63:0]       w_d64;
    logic              w_split;
    logic              w_idle;
    logic              w_accept;
    logic              w_hi;
    logic [ADDR_W-1:0] w_lo_addr;

    // lane math works only from the registered request, so st_* never reaches dmem_*
    store_lane_align u_align (
        .i_off   (r_addr[1:0]),
        .i_size  (r_size),
        .i_data  (r_data),
        .o_m8    (w_m8),
        .o_d64   (w_d64),
        .o_split (w_split)
    );

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = w_idle && st_valid_i && (st_size_i != SZ_X);
    assign w_lo_addr = {r_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_size  <= SZ_B;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_idle && st_valid_i && (st_size_i == SZ_X);
            if (w_accept) begin
                r_addr <= st_addr_i;
                r_size <= st_size_i;
                r_data <= st_data_i;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_accept ? ST_WR0 : ST_IDLE;
            ST_WR0:  w_next = dmem_ready_i ? (w_split ? ST_WR1 : ST_DONE) : ST_WR0;
            ST_WR1:  w_next = dmem_ready_i ? ST_DONE : ST_WR1;
            default: w_next = ST_IDLE;
        endcase
        w_hi         = (r_state == ST_WR1);
        dmem_we_o    = (r_state == ST_WR0) || w_hi;
        dmem_be_o    = !dmem_we_o ? 4'b0000 : w_hi ? w_m8[7:4] : w_m8[3:0];
        dmem_wdata_o = !dmem_we_o ? 32'b0 : w_hi ? w_d64[63:32] : w_d64[31:0];
        // high beat address wraps naturally at ADDR_W bits
        dmem_addr_o  = !dmem_we_o ? '0 : w_hi ? w_lo_addr + ADDR_W'(4) : w_lo_addr;
        st_ready_o   = w_idle;
        stall_o      = (st_valid_i && !w_idle) || dmem_we_o;
        done_o       = (r_state == ST_DONE);
        err_o        = r_err;
    end
endmodule

// File: tb/tb_dmem_store_unit.sv
// tb_dmem_store_unit: scoreboard bench for dmem_store_unit.
module tb_dmem_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid_i = 1'b0;
    logic        st_ready_o;
    logic [31:0] st_addr_i = '0;
    logic [1:0]  st_size_i = '0;
    logic [31:0] st_data_i = '0;
    logic        dmem_we_o;
    logic        dmem_ready_i = 1'b1;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        stall_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [67:0] sb_q[$];

    always #5 clk = ~clk;

    dmem_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
        .st_addr_i(st_addr_i), .st_size_i(st_size_i), .st_data_i(st_data_i),
        .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .stall_o(stall_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // byte-by-byte model: each byte lands at its own address, grouped by word
    task automatic push_beats(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                              output int nbeats);
        logic [31:0] lo, ba;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        int n;
        lo = a & 32'hFFFF_FFFC;
        be0 = '0; be1 = '0; wd0 = '0; wd1 = '0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if ((ba & 32'hFFFF_FFFC) == lo) begin
                be0[ba[1:0]] = 1'b1;
                wd0[8*ba[1:0] +: 8] = d[8*i +: 8];
            end else begin
                be1[ba[1:0]] = 1'b1;
                wd1[8*ba[1:0] +: 8] = d[8*i +: 8];
            end
        end
        sb_q.push_back({lo, be0, wd0});
        nbeats = 1;
        if (be1 != 0) begin
            sb_q.push_back({lo + 32'd4, be1, wd1});
            nbeats = 2;
        end
    endtask

    logic        p_we = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;

    always @(negedge clk) begin
        logic [67:0] e;
        if (p_we && !p_rdy && !p_rst) begin
            chk("hold_we", dmem_we_o, 1);
            chk("hold_bus", {dmem_addr_o, dmem_be_o, dmem_wdata_o}, {p_addr, p_be, p_wdata});
        end
        if (dmem_we_o && dmem_ready_i && !rst) begin
            if (sb_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = sb_q.pop_front();
                chk("wr_addr", dmem_addr_o, e[67:36]);
                chk("wr_be", dmem_be_o, e[35:32]);
                chk("wr_wdata", dmem_wdata_o, e[31:0]);
            end
        end
        p_we = dmem_we_o; p_rdy = dmem_ready_i; p_rst = rst;
        p_addr = dmem_addr_o; p_be = dmem_be_o; p_wdata = dmem_wdata_o;
    end

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            input int nwait);
        int nb, k;
        bit seen;
        push_beats(a, sz, d, nb);
        @(posedge clk) #1;
        st_valid_i = 1'b1; st_addr_i = a; st_size_i = sz; st_data_i = d;
        @(posedge clk) #1;
        st_valid_i = 1'b0;
        k = 1;
        seen = 0;
        dmem_ready_i = (k > nwait);
        while (k <= 20) begin
            @(negedge clk);
            if (dmem_we_o) begin
                chk("stall_busy", stall_o, 1);
                chk("ready_busy", st_ready_o, 0);
            end
            if (done_o) begin
                seen = 1;
                break;
            end
            @(posedge clk) #1;
            k++;
            dmem_ready_i = (k > nwait);
        end
        if (!seen) chk("done_timeout", 0, 1);
        else chk("done_latency", 64'(k), 64'(nb + 1 + nwait));
        chk("sb_drained", 64'(sb_q.size()), 0);
        dmem_ready_i = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", st_ready_o, 1);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_bus", {dmem_addr_o, dmem_be_o, dmem_wdata_o}, 0);
        chk("rst_flags", {stall_o, done_o, err_o}, 0);

        do_store(32'h0000_0100, 2'b10, 32'hDEAD_BEEF, 0);
        do_store(32'h0000_0203, 2'b00, 32'h0000_00A5, 0);
        do_store(32'h0000_0103, 2'b01, 32'h0000_1234, 0);
        do_store(32'hFFFF_FFFE, 2'b10, 32'hAABB_CCDD, 0);
        do_store(32'h0000_0040, 2'b10, 32'h1357_9BDF, 3);
        do_store(32'h0000_0081, 2'b00, 32'hFFFF_FF5A, 1);
        for (int i = 0; i < 8; i++)
            do_store($urandom, 2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 2));

        @(posedge clk) #1;
        st_valid_i = 1'b1; st_addr_i = 32'h10; st_size_i = 2'b11; st_data_i = 32'h1;
        @(posedge clk) #1;
        st_valid_i = 1'b0;
        @(negedge clk);
        chk("err_pulse", err_o, 1);
        chk("err_no_we", dmem_we_o, 0);
        chk("err_idle", st_ready_o, 1);
        @(posedge clk) #1;
        @(negedge clk);
        chk("err_once", err_o, 0);
        chk("err_no_we2", dmem_we_o, 0);

        sb_q.push_back({32'h0000_0100, 4'b1000, 32'h3400_0000});
        @(posedge clk) #1;
        st_valid_i = 1'b1; st_addr_i = 32'h103; st_size_i = 2'b01; st_data_i = 32'h1234;
        @(posedge clk) #1;
        st_valid_i = 1'b0;
        dmem_ready_i = 1'b1;
        @(posedge clk) #1;
        dmem_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wr1_we", dmem_we_o, 1);
        chk("wr1_addr", dmem_addr_o, 32'h104);
        @(posedge clk) #1;
        rst = 1'b0;
        dmem_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_we", dmem_we_o, 0);
        chk("rst_mid_idle", st_ready_o, 1);
        chk("rst_mid_done", done_o, 0);
        @(posedge clk) #1;
        @(negedge clk);
        chk("rst_mid_done2", done_o, 0);
        chk("rst_mid_sb", 64'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
